// File: rtl/wb_arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter in front of the SRAM port.
// Defines the FSM states, the master index type and the default bus widths.
package wb_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 23;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    function automatic master_t other(input master_t m);
        return (m == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone link. dat_m carries write data (master to slave) and
// dat_s carries read data (slave to master).
interface wb_if
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat_m;
    logic [DATA_WIDTH-1:0] dat_s;
    logic                  ack;
    logic                  err;
    logic                  rty;
    logic                  stall;

    modport master (
        output cyc, stb, we, adr, dat_m,
        input  dat_s, ack, err, rty, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_m,
        output dat_s, ack, err, rty, stall
    );
endinterface

// File: rtl/wb_txn_tracker.sv
// Counts accepted-but-unanswered strobes and runs the no-response watchdog.
// Responses that arrive with nothing outstanding do not move the counter.
module wb_txn_tracker
    import wb_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 3,
    parameter int TIMEOUT         = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       accept,
    input  logic       response,
    input  logic       clear,
    output logic [2:0] count,
    output logic       full,
    output logic       empty,
    output logic       timeout,
    output logic       resp_valid
);
    logic [7:0] timer;

    assign empty      = (count == 3'd0);
    assign full       = (count == 3'(MAX_OUTSTANDING));
    assign timeout    = (timer == 8'(TIMEOUT));
    assign resp_valid = response & ~empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= 3'd0;
            timer <= 8'd0;
        end else if (clear) begin
            count <= 3'd0;
            timer <= 8'd0;
        end else begin
            if (accept && !resp_valid) begin
                count <= count + 3'd1;
            end else if (!accept && resp_valid) begin
                count <= count - 3'd1;
            end
            // Any response, even a stray one, proves the slave is alive.
            if (empty || response) begin
                timer <= 8'd0;
            end else begin
                timer <= timer + 8'd1;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between two masters.
// A grant lasts a whole cyc session; orphaned responses are drained before regrant.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 3,
    parameter int TIMEOUT         = 255
) (
    input logic clk_i,
    input logic rst_ni,
    wb_if.slave  m0,
    wb_if.slave  m1,
    wb_if.master s
);
    arb_state_t state;
    master_t    owner;
    master_t    last;

    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       timeout;
    logic       resp_valid;
    logic       accept;
    logic       response;
    logic       clear;
    logic       drain_done;

    logic                  own_cyc;
    logic                  own_stb;
    logic                  own_we;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [DATA_WIDTH-1:0] own_dat;

    logic                  s_cyc_c;
    logic                  s_stb_c;
    logic                  s_we_c;
    logic [ADDR_WIDTH-1:0] s_adr_c;
    logic [DATA_WIDTH-1:0] s_dat_c;
    logic                  rsp_stall;
    logic                  rsp_ack;
    logic                  rsp_err;
    logic                  rsp_rty;
    logic                  m0_sel;
    logic                  m1_sel;

    assign own_cyc = (owner == M1) ? m1.cyc   : m0.cyc;
    assign own_stb = (owner == M1) ? m1.stb   : m0.stb;
    assign own_we  = (owner == M1) ? m1.we    : m0.we;
    assign own_adr = (owner == M1) ? m1.adr   : m0.adr;
    assign own_dat = (owner == M1) ? m1.dat_m : m0.dat_m;

    assign response   = s.ack | s.err | s.rty;
    assign accept     = s_stb_c & ~s.stall;
    assign clear      = timeout & (state != IDLE);
    assign drain_done = empty | ((count == 3'd1) & resp_valid);

    wb_txn_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TIMEOUT         (TIMEOUT)
    ) u_tracker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .accept     (accept),
        .response   (response),
        .clear      (clear),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .timeout    (timeout),
        .resp_valid (resp_valid)
    );

    always_comb begin
        s_cyc_c   = 1'b0;
        s_stb_c   = 1'b0;
        s_we_c    = 1'b0;
        s_adr_c   = '0;
        s_dat_c   = '0;
        rsp_stall = 1'b1;
        rsp_ack   = 1'b0;
        rsp_err   = 1'b0;
        rsp_rty   = 1'b0;
        case (state)
            BUSY: begin
                if (timeout) begin
                    // Watchdog abort: release the slave and report the failure.
                    rsp_err = 1'b1;
                end else begin
                    s_cyc_c   = own_cyc;
                    s_stb_c   = own_cyc & own_stb & ~full;
                    s_we_c    = own_we;
                    s_adr_c   = own_adr;
                    s_dat_c   = own_dat;
                    rsp_stall = s.stall | full;
                    rsp_ack   = s.ack & ~empty;
                    rsp_err   = s.err & ~empty;
                    rsp_rty   = s.rty & ~empty;
                end
            end
            DRAIN: begin
                s_cyc_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign s.cyc   = s_cyc_c;
    assign s.stb   = s_stb_c;
    assign s.we    = s_we_c;
    assign s.adr   = s_adr_c;
    assign s.dat_m = s_dat_c;

    assign m0_sel = (state == BUSY) && (owner == M0);
    assign m1_sel = (state == BUSY) && (owner == M1);

    assign m0.stall = m0_sel ? rsp_stall : 1'b1;
    assign m0.ack   = m0_sel & rsp_ack;
    assign m0.err   = m0_sel & rsp_err;
    assign m0.rty   = m0_sel & rsp_rty;
    assign m0.dat_s = s.dat_s;

    assign m1.stall = m1_sel ? rsp_stall : 1'b1;
    assign m1.ack   = m1_sel & rsp_ack;
    assign m1.err   = m1_sel & rsp_err;
    assign m1.rty   = m1_sel & rsp_rty;
    assign m1.dat_s = s.dat_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            owner <= M0;
            last  <= M1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.cyc && m1.cyc) begin
                        owner <= other(last);
                        last  <= other(last);
                        state <= BUSY;
                    end else if (m0.cyc) begin
                        owner <= M0;
                        last  <= M0;
                        state <= BUSY;
                    end else if (m1.cyc) begin
                        owner <= M1;
                        last  <= M1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (timeout) begin
                        state <= IDLE;
                    end else if (!own_cyc) begin
                        state <= drain_done ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (timeout || drain_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table for BUSY forwarding, hand-written
// sequences for arbitration, drain, watchdog and asynchronous reset.
module tb_wb_arbiter;
    localparam int AW = 23;
    localparam int DW = 8;
    localparam int TO = 8;

    logic clk;
    logic rst_ni;

    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

    wb_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (3),
        .TIMEOUT         (TO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .m0     (m0_bus.slave),
        .m1     (m1_bus.slave),
        .s      (s_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } req_t;

    typedef struct {
        logic          stb;
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          ack;
        logic          err;
        logic          rty;
        logic          stall;
        logic          e_stb;
        logic          e_stall;
        logic          e_ack;
        logic          e_err;
        logic          e_rty;
    } vec_t;

    req_t exp_q[$];
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe the slave accepts must match the next expected request.
    always @(negedge clk) begin
        req_t r;
        if (rst_ni && s_bus.cyc && s_bus.stb && !s_bus.stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_strobe actual_adr=%0h expected=none", s_bus.adr);
            end else begin
                r = exp_q.pop_front();
                check("sb_adr", 32'(s_bus.adr), 32'(r.adr));
                check("sb_dat", 32'(s_bus.dat_m), 32'(r.dat));
                check("sb_we", 32'(s_bus.we), 32'(r.we));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_set(input logic cyc, input logic stb, input logic we,
                          input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
        m0_bus.adr = adr; m0_bus.dat_m = dat;
    endtask

    task automatic slave_set(input logic ack, input logic err, input logic rty, input logic stall);
        s_bus.ack = ack; s_bus.err = err; s_bus.rty = rty; s_bus.stall = stall;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [DW-1:0] rd;
        int errs;
        int err_k;

        //                stb we adr    dat    ack err rty stl  e_stb e_stall e_ack e_err e_rty
        vecs[0]  = '{1'b1, 1'b1, 23'd2, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 23'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 23'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 23'd3, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 23'd3, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 23'd4, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 23'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 23'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 23'd6, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 23'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 23'd8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 23'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 23'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 23'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_ni = 1'b0;
        m0_set(1'b0, 1'b0, 1'b0, '0, '0);
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
        m1_bus.adr = '0; m1_bus.dat_m = '0;
        slave_set(1'b0, 1'b0, 1'b0, 1'b0);
        s_bus.dat_s = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_cyc", 32'(s_bus.cyc), 32'd0);
        check("rst_s_stb", 32'(s_bus.stb), 32'd0);
        check("rst_s_adr", 32'(s_bus.adr), 32'd0);
        check("rst_m0_stall", 32'(m0_bus.stall), 32'd1);
        check("rst_m1_stall", 32'(m1_bus.stall), 32'd1);
        check("rst_m0_ack", 32'(m0_bus.ack), 32'd0);

        // Tie after reset: master 0 must win
        next_cycle();
        rst_ni = 1'b1;
        m0_bus.cyc = 1'b1;
        m1_bus.cyc = 1'b1;
        @(negedge clk);
        check("tie_idle_m0_stall", 32'(m0_bus.stall), 32'd1);
        next_cycle();

        // BUSY forwarding table with master 0 as owner
        for (int i = 0; i < 14; i++) begin
            m0_set(1'b1, vecs[i].stb, vecs[i].we, vecs[i].adr, vecs[i].dat);
            slave_set(vecs[i].ack, vecs[i].err, vecs[i].rty, vecs[i].stall);
            rd = 8'($urandom);
            s_bus.dat_s = rd;
            if (vecs[i].e_stb && !vecs[i].stall)
                exp_q.push_back('{vecs[i].we, vecs[i].adr, vecs[i].dat});
            @(negedge clk);
            check($sformatf("v%0d_s_stb", i), 32'(s_bus.stb), 32'(vecs[i].e_stb));
            check($sformatf("v%0d_m0_stall", i), 32'(m0_bus.stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_m0_ack", i), 32'(m0_bus.ack), 32'(vecs[i].e_ack));
            check($sformatf("v%0d_m0_err", i), 32'(m0_bus.err), 32'(vecs[i].e_err));
            check($sformatf("v%0d_m0_rty", i), 32'(m0_bus.rty), 32'(vecs[i].e_rty));
            check($sformatf("v%0d_m1_stall", i), 32'(m1_bus.stall), 32'd1);
            check($sformatf("v%0d_m1_ack", i), 32'(m1_bus.ack), 32'd0);
            check($sformatf("v%0d_m0_dat", i), 32'(m0_bus.dat_s), 32'(rd));
            check($sformatf("v%0d_m1_dat", i), 32'(m1_bus.dat_s), 32'(rd));
            next_cycle();
        end

        // Handover: release, one IDLE cycle, then master 1
        slave_set(1'b0, 1'b0, 1'b0, 1'b0);
        m0_set(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rel_s_cyc", 32'(s_bus.cyc), 32'd0);
        next_cycle();
        @(negedge clk);
        check("gap_s_cyc", 32'(s_bus.cyc), 32'd0);
        check("gap_m1_stall", 32'(m1_bus.stall), 32'd1);
        next_cycle();
        @(negedge clk);
        check("hand_m1_stall", 32'(m1_bus.stall), 32'd0);
        check("hand_m0_stall", 32'(m0_bus.stall), 32'd1);
        check("hand_s_cyc", 32'(s_bus.cyc), 32'd1);

        // Round robin: master 1 releases, both request again, master 0 wins
        next_cycle();
        m1_bus.cyc = 1'b0;
        m0_bus.cyc = 1'b1;
        next_cycle();
        m1_bus.cyc = 1'b1;
        @(negedge clk);
        check("rr_idle_m0_stall", 32'(m0_bus.stall), 32'd1);
        next_cycle();
        @(negedge clk);
        check("rr_m0_stall", 32'(m0_bus.stall), 32'd0);
        check("rr_m1_stall", 32'(m1_bus.stall), 32'd1);

        // Drain: master 0 drops cyc with two strobes outstanding
        next_cycle();
        m0_set(1'b1, 1'b1, 1'b1, 23'h20, 8'h33);
        exp_q.push_back('{1'b1, 23'h20, 8'h33});
        next_cycle();
        m0_set(1'b1, 1'b1, 1'b1, 23'h21, 8'h34);
        exp_q.push_back('{1'b1, 23'h21, 8'h34});
        next_cycle();
        m0_set(1'b0, 1'b0, 1'b0, '0, '0);
        next_cycle();
        slave_set(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("drain_s_cyc", 32'(s_bus.cyc), 32'd1);
        check("drain_s_stb", 32'(s_bus.stb), 32'd0);
        check("drain_m0_stall", 32'(m0_bus.stall), 32'd1);
        check("drain_m1_stall", 32'(m1_bus.stall), 32'd1);
        check("drain_m0_ack1", 32'(m0_bus.ack), 32'd0);
        check("drain_m1_ack1", 32'(m1_bus.ack), 32'd0);
        next_cycle();
        @(negedge clk);
        check("drain_s_cyc2", 32'(s_bus.cyc), 32'd1);
        check("drain_m0_ack2", 32'(m0_bus.ack), 32'd0);
        next_cycle();
        slave_set(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("drain_idle_s_cyc", 32'(s_bus.cyc), 32'd0);
        check("drain_idle_m1_stall", 32'(m1_bus.stall), 32'd1);
        next_cycle();
        @(negedge clk);
        check("drain_m1_grant", 32'(m1_bus.stall), 32'd0);

        // Watchdog: one strobe accepted, the slave never answers
        next_cycle();
        m1_bus.cyc = 1'b0;
        m0_bus.cyc = 1'b1;
        next_cycle();
        next_cycle();
        m0_set(1'b1, 1'b1, 1'b0, 23'h40, 8'h00);
        exp_q.push_back('{1'b0, 23'h40, 8'h00});
        @(negedge clk);
        check("wd_accept_stall", 32'(m0_bus.stall), 32'd0);
        next_cycle();
        m0_set(1'b1, 1'b0, 1'b0, '0, '0);
        errs = 0;
        err_k = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (errs == 1 && k == err_k + 1) begin
                check("wd_after_s_cyc", 32'(s_bus.cyc), 32'd0);
                check("wd_after_m0_stall", 32'(m0_bus.stall), 32'd1);
            end
            if (m0_bus.err) begin
                errs++;
                err_k = k;
                check("wd_err_s_cyc", 32'(s_bus.cyc), 32'd0);
            end
            next_cycle();
        end
        check("wd_err_pulses", 32'(errs), 32'd1);
        check("wd_err_offset", 32'(err_k == TO || err_k == TO + 1), 32'd1);

        // Asynchronous reset mid-burst with two strobes outstanding
        m0_set(1'b1, 1'b1, 1'b1, 23'h50, 8'h66);
        exp_q.push_back('{1'b1, 23'h50, 8'h66});
        next_cycle();
        m0_set(1'b1, 1'b1, 1'b1, 23'h51, 8'h67);
        exp_q.push_back('{1'b1, 23'h51, 8'h67});
        next_cycle();
        m0_set(1'b1, 1'b0, 1'b0, '0, '0);
        #1;
        check("arst_pre_s_cyc", 32'(s_bus.cyc), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_s_cyc", 32'(s_bus.cyc), 32'd0);
        check("arst_s_adr", 32'(s_bus.adr), 32'd0);
        check("arst_m0_stall", 32'(m0_bus.stall), 32'd1);
        check("arst_m1_stall", 32'(m1_bus.stall), 32'd1);
        next_cycle();
        rst_ni = 1'b1;
        m1_bus.cyc = 1'b1;
        @(negedge clk);
        check("arst_idle_m0_stall", 32'(m0_bus.stall), 32'd1);
        next_cycle();
        @(negedge clk);
        check("arst_tie_m0_stall", 32'(m0_bus.stall), 32'd0);
        check("arst_tie_m1_stall", 32'(m1_bus.stall), 32'd1);

        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
